imem_fetch: RTL and testbench
=============================

# imem_fetch

Parametrised instruction memory for the RISC-V core with a registered, handshaked fetch port and a byte-enabled program-load write port. It sits between the fetch stage and the program loader. It replaces the fixed 128-word, combinational-read instruction memory with a one-cycle-latency synchronous read, write-to-fetch forwarding, and fault reporting. An optional power-on sweep fills the array with NOPs.

## Interface
Parameters:
- XLEN, 32, data and address width in bits (multiple of 8)
- DEPTH, 128, number of XLEN-bit words (power of two)
- AW (localparam), $clog2(DEPTH), word-index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch request
- fetch_pc  in  XLEN  fetch byte address
- fetch_ready  out  1  fetch port can accept a request this cycle
- fetch_valid  out  1  response valid (one-cycle pulse per accepted request)
- fetch_instr  out  XLEN  fetched word
- fetch_fault  out  1  response is for a misaligned or out-of-range pc
- wr_en  in  1  load write strobe
- wr_addr  in  XLEN  load byte address (bits [1:0] ignored)
- wr_be  in  XLEN/8  byte enables
- wr_data  in  XLEN  load data
- busy  out  1  NOP sweep in progress

## Operation
- Word index: addr[AW+1:2]. An address is out of range if any bit above AW+1 is set.
- Fetch accept: fetch_req && fetch_ready.
  - Aligned, in-range pc: response next cycle with fetch_instr = mem[idx], fetch_fault = 0.
  - Misaligned pc (pc[1:0] != 0) or out-of-range pc: fetch_instr = 32'h00000013 (NOP, zero-extended to XLEN), fetch_fault = 1.
- Write: when wr_en is high, busy is low, and wr_addr is in range, each byte lane with wr_be set is updated at the clock edge. Out-of-range writes are silently dropped.
- Forwarding: a same-cycle accepted fetch and write to the same word returns the merged value (write-first, per byte lane).
- fetch_ready = !busy. The fetch port never stalls in RUN.
- FSM states:
  - INIT: counter idx 0..DEPTH-1, writes NOP to mem[idx] each cycle, busy = 1. On idx == DEPTH-1, move to RUN.
  - RUN: normal operation, busy = 0.
- While busy, fetch requests are not accepted and wr_en is ignored.

## Timing
- Reset values: fetch_valid = 0, fetch_fault = 0, fetch_instr = NOP, sweep counter = 0.
  - With the macro: busy = 1, fetch_ready = 0.
  - Without the macro: busy = 0, fetch_ready = 1.
- Fetch latency: exactly 1 cycle, accept edge to fetch_valid. Back-to-back requests give one response every cycle.
- fetch_valid drops the cycle after a cycle with no accepted request. fetch_instr and fetch_fault hold their last values when fetch_valid is low.
- Sweep duration: DEPTH cycles after reset deassertion. First accept is possible on cycle DEPTH.
- Reset asserted mid-sweep or mid-fetch: outputs return to reset values immediately (async), any pending response is discarded, and the sweep restarts from 0. Array contents are not touched by reset itself.
- Write then fetch of the same word on the next cycle returns the new data (no hazard).

## Configuration
- IMEM_INIT_NOP_EN defined: FSM includes INIT. After every reset the whole array reads as NOP before the first fetch.
- Not defined: FSM is reduced to RUN only, busy is tied to 0, and array contents after power-up are undefined. They are loaded only via the write port or a simulation $readmemh.

## Structure
- Shared package rv_pkg holds:
  - the NOP encoding constant RV_NOP = 32'h00000013
  - the imem_state_e enum (INIT, RUN)
  - a word-index/range-check function parameterised on AW
- One sub-module, imem_bram: DEPTH x XLEN array with a synchronous read port and a byte-enabled write port. Forwarding, fault logic, and the FSM live in imem_fetch.

## Test plan
- Reset with macro, DEPTH = 128: busy high for 128 cycles, then fetch pc = 0x0 gives fetch_instr = 0x00000013, fetch_fault = 0.
- Write wr_addr = 0x8, wr_be = 4'b1111, wr_data = 0x02f707b3; next cycle fetch pc = 0x8 gives 0x02f707b3 one cycle later.
- Byte merge: word 0x10 holds 0x00e780a3; write wr_be = 4'b0001, data 0x000000ff; fetch gives 0x00e780ff.
- Same-cycle fetch and write to 0xC with data 0x0ff7f713 gives a forwarded 0x0ff7f713.
- Fault cases: fetch pc = 0x6 and pc = 0x200 each give fetch_fault = 1 and NOP. A write to 0x200 leaves word 0 unchanged.
- Reset asserted at sweep cycle 40: busy stays high, then a full 128-cycle sweep follows after deassertion, and fetch_valid remains 0 throughout.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V constants, the instruction-memory FSM state type and
// address helpers used by imem_fetch and its array.
package rv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  // Word index of a byte address for an array with 2**aw words.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int unsigned aw);
    word_index = (addr >> 2) & ((64'd1 << aw) - 64'd1);
  endfunction

  // True when no address bit above the word index is set.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned aw);
    addr_in_range = ((addr >> (aw + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/imem_bram.sv
// DEPTH x XLEN instruction array: synchronous registered read, byte-enabled
// write. A same-edge read returns the pre-write contents.
module imem_bram
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]          rd_data,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [XLEN/8-1:0]        wr_be,
  input  logic [XLEN-1:0]          wr_data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_data_q;
  logic [XLEN-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  // Output register resets to NOP so the fetch port shows NOP out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= XLEN'(RV_NOP);
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a one-cycle handshaked fetch port, write-to-fetch
// forwarding and fault reporting. IMEM_INIT_NOP_EN adds a NOP fill after reset.
module imem_fetch
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_instr,
  output logic              fetch_fault,
  input  logic              wr_en,
  input  logic [XLEN-1:0]   wr_addr,
  input  logic [XLEN/8-1:0] wr_be,
  input  logic [XLEN-1:0]   wr_data,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] NOP_W = XLEN'(RV_NOP);

  // Handshake: a fetch is accepted on a rising edge where fetch_req and
  // fetch_ready are both high; fetch_valid pulses exactly one cycle later.
  imem_state_e     state;
  logic            busy_int;
  logic            init_we;
  logic [AW-1:0]   init_idx;

`ifdef IMEM_INIT_NOP_EN
  imem_state_e   state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          sweep_d = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign state    = state_q;
  assign init_idx = sweep_q;
`else
  assign state    = RUN;
  assign init_idx = '0;
`endif

  assign busy_int    = (state == INIT);
  assign init_we     = busy_int;
  assign busy        = busy_int;
  assign fetch_ready = !busy_int;

  logic [AW-1:0] fetch_idx, wr_idx;
  logic          fetch_bad, wr_ok, accept, run_we;

  assign fetch_idx = AW'(word_index(64'(fetch_pc), AW));
  assign wr_idx    = AW'(word_index(64'(wr_addr), AW));
  assign fetch_bad = (fetch_pc[1:0] != 2'b00) || !addr_in_range(64'(fetch_pc), AW);
  assign wr_ok     = addr_in_range(64'(wr_addr), AW);
  assign accept    = fetch_req && !busy_int;
  assign run_we    = wr_en && !busy_int && wr_ok;

  logic            bram_we;
  logic [AW-1:0]   bram_wr_idx;
  logic [NB-1:0]   bram_be;
  logic [XLEN-1:0] bram_wdata;
  logic [XLEN-1:0] rd_data;

  always_comb begin
    bram_we     = init_we || run_we;
    bram_wr_idx = init_we ? init_idx : wr_idx;
    bram_be     = init_we ? {NB{1'b1}} : wr_be;
    bram_wdata  = init_we ? NOP_W : wr_data;
  end

  imem_bram #(.XLEN(XLEN), .DEPTH(DEPTH)) u_bram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (accept && !fetch_bad),
    .rd_idx  (fetch_idx),
    .rd_data (rd_data),
    .we      (bram_we),
    .wr_idx  (bram_wr_idx),
    .wr_be   (bram_be),
    .wr_data (bram_wdata)
  );

  // The array returns pre-write data on a same-edge collision, so the
  // colliding write lanes are captured here and overlaid on the response.
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [NB-1:0]   fwd_be_q, fwd_be_d;
  logic [XLEN-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    valid_d    = accept;
    fault_d    = fault_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
    if (accept) begin
      fault_d    = fetch_bad;
      fwd_be_d   = (!fetch_bad && run_we && (wr_idx == fetch_idx)) ? wr_be : '0;
      fwd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  logic [XLEN-1:0] merged;

  always_comb begin
    merged = rd_data;
    for (int b = 0; b < NB; b++) begin
      if (fwd_be_q[b]) merged[b*8 +: 8] = fwd_data_q[b*8 +: 8];
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;
  assign fetch_instr = fault_q ? NOP_W : merged;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: directed fetch/write vectors with
// hand-computed responses; covers both IMEM_INIT_NOP_EN builds.
module tb_imem_fetch;

  localparam int XLEN  = 32;
  localparam int DEPTH = 128;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_instr;
  logic            fetch_fault;
  logic            wr_en;
  logic [XLEN-1:0] wr_addr;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [XLEN:0] exp_q[$];

  imem_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_be       (wr_be),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%h need=%h", name, got, need);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got=%h need=none", {fetch_fault, fetch_instr});
      end else begin
        logic [XLEN:0] e;
        e = exp_q.pop_front();
        check("fetch_resp", {31'd0, fetch_fault, fetch_instr}, {31'd0, e});
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                       input logic fault);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    exp_q.push_back({fault, instr});
    step();
    fetch_req = 1'b0;
  endtask

  task automatic write(input logic [XLEN-1:0] addr, input logic [3:0] be,
                       input logic [XLEN-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_be   = be;
    wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fetch_write(input logic [XLEN-1:0] addr, input logic [3:0] be,
                             input logic [XLEN-1:0] data, input logic [XLEN-1:0] instr);
    wr_en     = 1'b1;
    wr_addr   = addr;
    wr_be     = be;
    wr_data   = data;
    fetch_req = 1'b1;
    fetch_pc  = addr;
    exp_q.push_back({1'b0, instr});
    step();
    wr_en     = 1'b0;
    fetch_req = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      step();
      cnt++;
    end
    check(name, 64'(cnt), 64'(DEPTH));
  endtask

  initial begin
    rst       = 1'b1;
    fetch_req = 1'b0;
    fetch_pc  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    step();
    step();

    check("rst_valid", 64'(fetch_valid), 64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    check("rst_instr", 64'(fetch_instr), 64'(NOP));
`ifdef IMEM_INIT_NOP_EN
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ready", 64'(fetch_ready), 64'd0);

    // Requests and writes during the sweep must be ignored.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    wr_en     = 1'b1;
    wr_addr   = 32'h0;
    wr_be     = 4'hf;
    wr_data   = 32'hffff_ffff;
    rst       = 1'b0;
    repeat (40) step();
    rst = 1'b1;
    #1;
    check("midsweep_busy", 64'(busy), 64'd1);
    check("midsweep_valid", 64'(fetch_valid), 64'd0);
    check("midsweep_instr", 64'(fetch_instr), 64'(NOP));
    step();
    step();
    rst = 1'b0;
    count_busy("sweep_len");
    fetch_req = 1'b0;
    wr_en     = 1'b0;
    check("run_ready", 64'(fetch_ready), 64'd1);
    fetch(32'h0, NOP, 1'b0);
    fetch(32'h1fc, NOP, 1'b0);
`else
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    rst = 1'b0;
    step();
`endif

    // Out-of-range write must not alias onto word 0.
    write(32'h0, 4'hf, 32'h1111_1111);
    write(32'h200, 4'hf, 32'hdead_beef);
    fetch(32'h0, 32'h1111_1111, 1'b0);

    write(32'h8, 4'hf, 32'h02f7_07b3);
    fetch(32'h8, 32'h02f7_07b3, 1'b0);

    write(32'h10, 4'hf, 32'h00e7_80a3);
    write(32'h10, 4'b0001, 32'h0000_00ff);
    fetch(32'h10, 32'h00e7_80ff, 1'b0);

    write(32'hc, 4'hf, 32'h1234_5678);
    fetch_write(32'hc, 4'hf, 32'h0ff7_f713, 32'h0ff7_f713);
    fetch_write(32'hc, 4'b0100, 32'h00ab_0000, 32'h0fab_f713);
    fetch(32'hc, 32'h0fab_f713, 1'b0);

    fetch(32'h6, NOP, 1'b1);
    fetch(32'h200, NOP, 1'b1);
    step();
    step();
    check("hold_valid", 64'(fetch_valid), 64'd0);
    check("hold_fault", 64'(fetch_fault), 64'd1);
    check("hold_instr", 64'(fetch_instr), 64'(NOP));

    // Back-to-back stream.
    fetch(32'h0, 32'h1111_1111, 1'b0);
    fetch(32'h8, 32'h02f7_07b3, 1'b0);
    fetch(32'h3, NOP, 1'b1);
    fetch(32'h10, 32'h00e7_80ff, 1'b0);
    fetch(32'hc, 32'h0fab_f713, 1'b0);
    step();
    step();
    check("hold_good_fault", 64'(fetch_fault), 64'd0);
    check("hold_good_instr", 64'(fetch_instr), 64'h0fab_f713);

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
